// File: rtl/dram_lsu_pkg.sv
// Shared encodings and FSM state type for the dram load/store sequencer.
package dram_lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_R = 2'b11;

  localparam logic [1:0] DATA_SEL_BYTE = 2'b10;

  typedef enum logic [2:0] {StIdle, StStore, StLoad, StLdLast, StResp} state_e;

  // Index of the last byte of an access (N-1).
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SIZE_B:  return 2'd0;
      SIZE_H:  return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/dram_lsu_ext.sv
// Sign/zero extender: turns the big-endian load accumulator into an XLEN result.
module dram_lsu_ext
  import dram_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] acc,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = '0;
    case (size)
      SIZE_B:  result = {{(XLEN-8){~is_unsigned & acc[7]}}, acc[7:0]};
      SIZE_H:  result = {{(XLEN-16){~is_unsigned & acc[15]}}, acc[15:0]};
      SIZE_W:  result = acc;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dram_lsu.sv
// Byte-serial load/store sequencer between the core and a byte-wide dram.
// Build option: DRAM_LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module dram_lsu
  import dram_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned XLEN   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_UNSIGNED,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [XLEN-1:0]   REQ_WDATA,
  output logic              RSP_VALID,
  output logic [XLEN-1:0]   RSP_RDATA,
  output logic              RSP_ERR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [1:0]        MEM_DATA_SEL,
  output logic              MEM_MW,
  output logic [7:0]        MEM_DATA_WRITE,
  input  logic [7:0]        MEM_DATA_BYTE
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wsh_q, wsh_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic              mw_q, mw_d;
  logic [7:0]        wbyte_q, wbyte_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [XLEN-1:0]   acc_sh;
  logic [XLEN-1:0]   ext_out;
  logic [XLEN-1:0]   wdata_al;
  logic              misalign;

  assign acc_sh = {acc_q[XLEN-9:0], MEM_DATA_BYTE};

  dram_lsu_ext #(
    .XLEN(XLEN)
  ) u_ext (
    .acc        (acc_sh),
    .size       (size_q),
    .is_unsigned(uns_q),
    .result     (ext_out)
  );

`ifdef DRAM_LSU_MISALIGN_CHECK_EN
  assign misalign = ((REQ_SIZE == SIZE_H) && REQ_ADDR[0]) ||
                    ((REQ_SIZE == SIZE_W) && (REQ_ADDR[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Left-justify store data so byte 0 (the MSB of the access) sits at the top.
  always_comb begin
    case (REQ_SIZE)
      SIZE_B:  wdata_al = REQ_WDATA << (XLEN - 8);
      SIZE_H:  wdata_al = REQ_WDATA << (XLEN - 16);
      default: wdata_al = REQ_WDATA;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wsh_d       = wsh_q;
    acc_d       = acc_q;
    wbyte_d     = wbyte_q;
    mw_d        = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      StIdle: begin
        if (REQ_VALID) begin
          size_d = REQ_SIZE;
          uns_d  = REQ_UNSIGNED;
          last_d = last_idx(REQ_SIZE);
          cnt_d  = 2'd0;
          addr_d = REQ_ADDR;
          acc_d  = '0;
          if ((REQ_SIZE == SIZE_R) || misalign) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (REQ_WE) begin
            state_d = StStore;
            mw_d    = 1'b1;
            wbyte_d = wdata_al[XLEN-1 -: 8];
            wsh_d   = wdata_al << 8;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StStore: begin
        if (cnt_q == last_q) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + 2'd1;
          addr_d  = addr_q + ADDR_W'(1);
          mw_d    = 1'b1;
          wbyte_d = wsh_q[XLEN-1 -: 8];
          wsh_d   = wsh_q << 8;
        end
      end
      StLoad: begin
        // Read data lags its address by one cycle, so byte i lands while byte i+1 is addressed.
        if (cnt_q != 2'd0) acc_d = acc_sh;
        if (cnt_q == last_q) begin
          state_d = StLdLast;
        end else begin
          cnt_d  = cnt_q + 2'd1;
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      StLdLast: begin
        acc_d       = acc_sh;
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ext_out;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      last_q      <= 2'd0;
      size_q      <= SIZE_B;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wsh_q       <= '0;
      acc_q       <= '0;
      mw_q        <= 1'b0;
      wbyte_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wsh_q       <= wsh_d;
      acc_q       <= acc_d;
      mw_q        <= mw_d;
      wbyte_q     <= wbyte_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign REQ_READY      = (state_q == StIdle);
  assign RSP_VALID      = rsp_valid_q;
  assign RSP_RDATA      = rsp_rdata_q;
  assign RSP_ERR        = rsp_err_q;
  assign MEM_ADDR       = addr_q;
  assign MEM_DATA_SEL   = DATA_SEL_BYTE;
  assign MEM_MW         = mw_q;
  assign MEM_DATA_WRITE = wbyte_q;

endmodule
